// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared state encoding and CDB constants for the CDB arbiter
package cdb_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;
  localparam int NO_RS = 0;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_SOURCE_W = 6;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: request/transmit handshake plus CDB snoop bundle
interface cdb_arbiter_if import cdb_arbiter_pkg::*; #(
  parameter int NUM_UNITS = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SOURCE_W = DEF_SOURCE_W
);
  logic [NUM_UNITS-1:0] rts;
  logic [NUM_UNITS-1:0] xmit;
  logic [DATA_W-1:0] cdb_data;
  logic [SOURCE_W-1:0] cdb_source;
  logic cdb_write;
  logic bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic [SOURCE_W-1:0] bus_source;
  logic busy;
  logic error;
  modport master (
    input rts, cdb_data, cdb_source, cdb_write,
    output xmit, bus_valid, bus_data, bus_source, busy, error
  );
  modport slave (
    output rts, cdb_data, cdb_source, cdb_write,
    input xmit, bus_valid, bus_data, bus_source, busy, error
  );
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// cdb_arbiter_rr_picker: first set request at or after ptr, wrapping, as one-hot and index
module cdb_arbiter_rr_picker #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    idx_o = '0;
    for (int o = N - 1; o >= 0; o--) begin
      if (req_i[PW'((int'(ptr_i) + o) % N)]) idx_o = PW'((int'(ptr_i) + o) % N);
    end
    any_o = |req_i;
    gnt_o = any_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB grant with fixed hold/gap windows and registered broadcast capture
module cdb_arbiter import cdb_arbiter_pkg::*; #(
  parameter int NUM_UNITS = 4,
  parameter int XMIT_CYCLES = 1,
  parameter int GAP_CYCLES = 1,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SOURCE_W = DEF_SOURCE_W
) (
  input logic clock_i,
  input logic reset_n_i,
  cdb_arbiter_if.master cdb
);
  localparam int PW = $clog2(NUM_UNITS);
  localparam int CW = $clog2(XMIT_CYCLES + GAP_CYCLES + 1);
  state_e state_q, state_d;
  logic [NUM_UNITS-1:0] xmit_q, xmit_d, gnt;
  logic [PW-1:0] idx_q, idx_d, rr_q, rr_d, pidx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SOURCE_W-1:0] src_q, src_d;
  logic valid_q, valid_d, err_q, err_d, busy_q, any, cap, good;
  cdb_arbiter_rr_picker #(.N(NUM_UNITS)) u_pick (
    .req_i(cdb.rts), .ptr_i(rr_q), .gnt_o(gnt), .idx_o(pidx), .any_o(any)
  );
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  assign cap = state_q == GRANT && cnt_q == '0;
  always_comb begin
    state_d = state_q == IDLE  ? (any ? GRANT : IDLE) :
              state_q == GRANT ? (cnt_q == '0 ? RELEASE : GRANT) :
                                 (cnt_q == '0 ? IDLE : RELEASE);
  end
  // a broadcast is only valid when the bus is actively written with a real tag
  assign good = cdb.cdb_write === 1'b1 && cdb.cdb_source != SOURCE_W'(NO_RS);
  always_comb begin
    cnt_d = state_q == IDLE ? CW'(XMIT_CYCLES - 1) : cap ? CW'(GAP_CYCLES - 1) : cnt_q - CW'(cnt_q != '0);
    xmit_d = state_q == IDLE ? gnt : cap ? '0 : xmit_q;
    idx_d = state_q == IDLE && any ? pidx : idx_q;
    rr_d = cap ? (idx_q == PW'(NUM_UNITS - 1) ? '0 : idx_q + PW'(1)) : rr_q;
    valid_d = cap && good;
    data_d = valid_d ? cdb.cdb_data : data_q;
    src_d = valid_d ? cdb.cdb_source : src_q;
    err_d = cap ? !good : state_q != GRANT && cdb.cdb_write === 1'b1;
  end
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      xmit_q <= '0;
      idx_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      src_q <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      xmit_q <= xmit_d;
      idx_q <= idx_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      data_q <= data_d;
      src_q <= src_d;
      err_q <= err_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign cdb.xmit = xmit_q;
  assign cdb.bus_valid = valid_q;
  assign cdb.bus_data = data_q;
  assign cdb.bus_source = src_q;
  assign cdb.busy = busy_q;
  assign cdb.error = err_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: two arbiter instances (1/1 and 3/2 hold/gap) against a timing-rule reference model
module tb_cdb_arbiter;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;
  logic [3:0] rts;
  logic bad_wr, bad_src, unsol;
  logic [3:0][31:0] udata;
  cdb_arbiter_if #(.NUM_UNITS(4), .DATA_W(32), .SOURCE_W(6)) if0 ();
  cdb_arbiter_if #(.NUM_UNITS(4), .DATA_W(32), .SOURCE_W(6)) if1 ();
  cdb_arbiter #(.NUM_UNITS(4), .XMIT_CYCLES(1), .GAP_CYCLES(1), .DATA_W(32), .SOURCE_W(6)) u0 (
    .clock_i(clock), .reset_n_i(reset_n), .cdb(if0)
  );
  cdb_arbiter #(.NUM_UNITS(4), .XMIT_CYCLES(3), .GAP_CYCLES(2), .DATA_W(32), .SOURCE_W(6)) u1 (
    .clock_i(clock), .reset_n_i(reset_n), .cdb(if1)
  );
  assign if0.rts = rts;
  assign if1.rts = rts;
  // the granted unit drives the bus; otherwise only a stray writer may
  function automatic void bus_of(input logic [3:0] xm, input logic bw, input logic bs, input logic un,
                                 input logic [3:0][31:0] ud, output logic w, output logic [5:0] s,
                                 output logic [31:0] d);
    w = un;
    s = '0;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (xm[i]) begin
        w = !bw;
        s = bs ? 6'd0 : 6'(i + 1);
        d = ud[i];
      end
    end
  endfunction
  always_comb bus_of(if0.xmit, bad_wr, bad_src, unsol, udata, if0.cdb_write, if0.cdb_source, if0.cdb_data);
  always_comb bus_of(if1.xmit, bad_wr, bad_src, unsol, udata, if1.cdb_write, if1.cdb_source, if1.cdb_data);
  int n, vectors, miscompares;
  int cur[2], gedge[2], free_at[2], ptr[2];
  logic ev[2], ee[2];
  logic [31:0] ed[2], sd[2];
  logic [5:0] es[2], ss[2];
  logic sw[2];
  logic [3:0] srts;
  logic srst;
  function automatic int pick(input logic [3:0] r, input int p);
    for (int o = 0; o < 4; o++) if (r[(p + o) % 4]) return (p + o) % 4;
    return -1;
  endfunction
  task automatic chk(input string tag, input int k, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    assert (a === e) else begin
      miscompares++;
      $error("FAIL %s inst%0d edge %0d: got %h want %h", tag, k, n, a, e);
    end
  endtask
  task automatic model(input int k);
    int x, g;
    x = k != 0 ? 3 : 1;
    g = k != 0 ? 2 : 1;
    if (!srst) begin
      cur[k] = -1;
      ptr[k] = 0;
      free_at[k] = n + 1;
      ev[k] = 0;
      ee[k] = 0;
      ed[k] = '0;
      es[k] = '0;
    end else begin
      ev[k] = 0;
      ee[k] = 0;
      if (cur[k] >= 0 && n == gedge[k] + x) begin
        if (sw[k] === 1'b1 && ss[k] != 0) begin
          ev[k] = 1;
          ed[k] = sd[k];
          es[k] = ss[k];
        end else ee[k] = 1;
        ptr[k] = (cur[k] + 1) % 4;
        cur[k] = -1;
        free_at[k] = n + g + 1;
      end else if (cur[k] < 0) begin
        ee[k] = sw[k] === 1'b1;
        if (n >= free_at[k] && srts != 0) begin
          cur[k] = pick(srts, ptr[k]);
          gedge[k] = n;
        end
      end
    end
  endtask
  task automatic check(input int k);
    logic [3:0] ex;
    logic eb;
    ex = cur[k] >= 0 ? 4'(1 << cur[k]) : 4'b0;
    eb = cur[k] >= 0 || n < free_at[k] - 1;
    chk("xmit", k, 32'(k != 0 ? if1.xmit : if0.xmit), 32'(ex));
    chk("busy", k, 32'(k != 0 ? if1.busy : if0.busy), 32'(eb));
    chk("bus_valid", k, 32'(k != 0 ? if1.bus_valid : if0.bus_valid), 32'(ev[k]));
    chk("error", k, 32'(k != 0 ? if1.error : if0.error), 32'(ee[k]));
    chk("bus_data", k, k != 0 ? if1.bus_data : if0.bus_data, ed[k]);
    chk("bus_source", k, 32'(k != 0 ? if1.bus_source : if0.bus_source), 32'(es[k]));
  endtask
  task automatic step();
    @(negedge clock);
    sw[0] = if0.cdb_write;
    ss[0] = if0.cdb_source;
    sd[0] = if0.cdb_data;
    sw[1] = if1.cdb_write;
    ss[1] = if1.cdb_source;
    sd[1] = if1.cdb_data;
    srts = rts;
    srst = reset_n;
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      model(k);
      check(k);
    end
    n++;
  endtask
  task automatic steps(input int c);
    for (int i = 0; i < c; i++) step();
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask
  initial begin
    n = 0;
    vectors = 0;
    miscompares = 0;
    for (int k = 0; k < 2; k++) begin
      cur[k] = -1;
      ptr[k] = 0;
      free_at[k] = 0;
      gedge[k] = 0;
    end
    reset_n = 1'b0;
    rts = '0;
    bad_wr = 1'b0;
    bad_src = 1'b0;
    unsol = 1'b0;
    for (int i = 0; i < 4; i++) udata[i] = 32'h100 * (i + 1);
    udata[1] = 32'h0000_00A5;
    steps(2);
    reset_n = 1'b1;
    step();
    rts = 4'b0010;
    step();
    chk("t1_xmit", 0, 32'(if0.xmit), 32'h2);
    rts = 4'b0000;
    step();
    chk("t1_valid", 0, 32'(if0.bus_valid), 32'h1);
    chk("t1_src", 0, 32'(if0.bus_source), 32'd2);
    chk("t1_data", 0, if0.bus_data, 32'h0000_00A5);
    steps(6);
    do_reset();
    rts = 4'b1111;
    steps(16);
    rts = 4'b0000;
    steps(6);
    do_reset();
    rts = 4'b0001;
    step();
    rts = 4'b0000;
    steps(6);
    rts = 4'b0011;
    steps(10);
    rts = 4'b0000;
    steps(6);
    bad_wr = 1'b1;
    rts = 4'b0100;
    step();
    rts = 4'b0000;
    steps(6);
    bad_wr = 1'b0;
    bad_src = 1'b1;
    rts = 4'b1000;
    step();
    rts = 4'b0000;
    steps(6);
    bad_src = 1'b0;
    do_reset();
    rts = 4'b0001;
    step();
    rts = 4'b0000;
    step();
    do_reset();
    rts = 4'b0100;
    step();
    rts = 4'b0000;
    steps(6);
    unsol = 1'b1;
    step();
    unsol = 1'b0;
    steps(3);
    for (int i = 0; i < 400; i++) begin
      rts = 4'($urandom);
      bad_wr = $urandom_range(7) == 0;
      bad_src = $urandom_range(7) == 0;
      unsol = $urandom_range(5) == 0;
      reset_n = $urandom_range(49) != 0;
      for (int j = 0; j < 4; j++) udata[j] = $urandom;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
